shift_link_tx: RTL and testbench

Parallel-to-serial transmitter that drives a chain of remote 74x194 universal shift registers over their serial inputs. It accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per bit period, LSB-first on the right-shift line or MSB-first on the left-shift line. For each bit it presents data, the 194 mode-select code and a shift strobe. It is the sending end of the serial load path into the register-file and I/O shift chains.

---
 rtl/shift_link_tx_if.sv | 12 +
 rtl/shift_link_tx.sv | 113 +++++++++++
 tb/tb_shift_link_tx.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/shift_link_tx_if.sv
// Word-level request side of the shift link transmitter: data, direction and valid/ready handshake.
interface shift_link_tx_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             dir;
    logic             valid;
    logic             ready;

    modport master (output data_in, output dir, output valid, input ready);
    modport slave  (input data_in, input dir, input valid, output ready);
endinterface

// File: rtl/shift_link_tx.sv
// Parallel-to-serial transmitter feeding a chain of remote 74x194 shift registers,
// one bit per DIV-cycle bit period with a mid-bit shift strobe.
module shift_link_tx #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV   = 4
) (
    input  logic              clock,
    input  logic              mr,
    shift_link_tx_if.slave    link,
    output logic              ser_dsr,
    output logic              ser_dsl,
    output logic [1:0]        sel,
    output logic              sclk,
    output logic              busy,
    output logic              done
);
    localparam int unsigned PH_W  = $clog2(DIV);
    localparam int unsigned BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state, state_n;
    logic [PH_W-1:0]    phase, phase_n;
    logic [BIT_W-1:0]   bit_idx, bit_n;
    logic [WIDTH-1:0]   shreg, shreg_n;
    logic               dreg, dreg_n;
    logic               ready_n, busy_n, done_n, sclk_n, dsr_n, dsl_n;
    logic [1:0]         sel_n;

    // State and output registers; outputs are loaded from the next-state decode
    always_ff @(posedge clock) begin
        if (!mr) begin
            state      <= IDLE;
            phase      <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            dreg       <= 1'b0;
            link.ready <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            sclk       <= 1'b0;
            sel        <= 2'b00;
            ser_dsr    <= 1'b0;
            ser_dsl    <= 1'b0;
        end else begin
            state      <= state_n;
            phase      <= phase_n;
            bit_idx    <= bit_n;
            shreg      <= shreg_n;
            dreg       <= dreg_n;
            link.ready <= ready_n;
            busy       <= busy_n;
            done       <= done_n;
            sclk       <= sclk_n;
            sel        <= sel_n;
            ser_dsr    <= dsr_n;
            ser_dsl    <= dsl_n;
        end
    end

    // Next-state logic, then output decode of the next state
    always_comb begin
        state_n = state;
        phase_n = phase;
        bit_n   = bit_idx;
        shreg_n = shreg;
        dreg_n  = dreg;
        ready_n = 1'b0;
        busy_n  = 1'b0;
        done_n  = 1'b0;
        sclk_n  = 1'b0;
        sel_n   = 2'b00;
        dsr_n   = 1'b0;
        dsl_n   = 1'b0;

        unique case (state)
            IDLE: begin
                if (link.valid) begin
                    state_n = SHIFT;
                    shreg_n = link.data_in;
                    dreg_n  = link.dir;
                    phase_n = '0;
                    bit_n   = '0;
                end
            end
            SHIFT: begin
                if (phase == PH_W'(DIV - 1)) begin
                    phase_n = '0;
                    if (bit_idx == BIT_W'(WIDTH - 1)) begin
                        state_n = DONE;
                    end else begin
                        bit_n   = bit_idx + BIT_W'(1);
                        shreg_n = dreg ? (shreg << 1) : (shreg >> 1);
                    end
                end else begin
                    phase_n = phase + PH_W'(1);
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase

        ready_n = (state_n == IDLE);
        busy_n  = (state_n != IDLE);
        done_n  = (state_n == DONE);
        if (state_n == SHIFT) begin
            sel_n  = dreg_n ? 2'b10 : 2'b01;
            dsr_n  = !dreg_n && shreg_n[0];
            dsl_n  = dreg_n && shreg_n[WIDTH-1];
            sclk_n = (phase_n >= PH_W'(DIV / 2));
        end
    end
endmodule

// File: tb/tb_shift_link_tx.sv
// Directed + randomized bench for shift_link_tx: cycle-exact waveform check at 8/4
// and a 74x194 loopback at 4/2.
module tb_shift_link_tx;
    localparam int unsigned W8 = 8;
    localparam int unsigned D8 = 4;
    localparam logic [7:0]  RST = 8'b1000_0000;

    logic clk;
    logic mr;
    int   tests = 0;
    int   fails = 0;

    shift_link_tx_if #(.WIDTH(8)) link8 ();
    shift_link_tx_if #(.WIDTH(4)) link4 ();

    logic       dsr8, dsl8, sclk8, busy8, done8;
    logic [1:0] sel8;
    logic       dsr4, dsl4, sclk4, busy4, done4;
    logic [1:0] sel4;
    logic [3:0] q;

    shift_link_tx #(.WIDTH(8), .DIV(4)) dut8 (
        .clock(clk), .mr(mr), .link(link8),
        .ser_dsr(dsr8), .ser_dsl(dsl8), .sel(sel8),
        .sclk(sclk8), .busy(busy8), .done(done8)
    );

    shift_link_tx #(.WIDTH(4), .DIV(2)) dut4 (
        .clock(clk), .mr(mr), .link(link4),
        .ser_dsr(dsr4), .ser_dsl(dsl4), .sel(sel4),
        .sclk(sclk4), .busy(busy4), .done(done4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural remote 74x194: DSR enters at the top on right shift, DSL at the bottom on left shift
    always @(posedge sclk4) begin
        case (sel4)
            2'b01:   q <= {dsr4, q[3:1]};
            2'b10:   q <= {q[2:0], dsl4};
            default: q <= q;
        endcase
    end

    function automatic logic [7:0] obs8();
        return {link8.ready, busy8, done8, sclk8, sel8, dsl8, dsr8};
    endfunction

    function automatic logic [7:0] obs4();
        return {link4.ready, busy4, done4, sclk4, sel4, dsl4, dsr4};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready8();
        int n;
        n = 0;
        while (link8.ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("ready_wait", 32'(link8.ready), 32'd1);
    endtask

    // One 8-bit transfer checked cycle by cycle; abort_at >= 0 pulses mr at that cycle index
    task automatic xfer8(input logic [7:0] d, input logic dr, input bit keep_valid, input int abort_at);
        logic [7:0] e;
        int         rises;
        logic       prev;
        wait_ready8();
        link8.valid   = 1'b1;
        link8.data_in = d;
        link8.dir     = dr;
        tick();
        rises = 0;
        prev  = 1'b0;
        for (int k = 0; k < int'(W8 * D8); k++) begin
            int   b;
            int   p;
            logic sb;
            b  = k / int'(D8);
            p  = k % int'(D8);
            sb = dr ? d[int'(W8) - 1 - b] : d[b];
            e  = {1'b0, 1'b1, 1'b0, 1'(p >= int'(D8 / 2)), (dr ? 2'b10 : 2'b01), dr & sb, !dr & sb};
            check($sformatf("d%02h_bit%0d_ph%0d", d, b, p), 32'(obs8()), 32'(e));
            if (sclk8 && !prev) rises++;
            prev = sclk8;
            if (k == abort_at) begin
                mr          = 1'b0;
                link8.valid = 1'($urandom);
                tick();
                check("abort_reset", 32'(obs8()), 32'(RST));
                mr          = 1'b1;
                link8.valid = 1'b0;
                repeat (W8 * D8) begin
                    tick();
                    check("abort_idle", 32'(obs8()), 32'(RST));
                end
                return;
            end
            link8.valid   = keep_valid ? 1'b1 : 1'($urandom);
            link8.data_in = 8'($urandom);
            link8.dir     = 1'($urandom);
            tick();
        end
        check($sformatf("d%02h_sclk_rises", d), 32'(rises), 32'(W8));
        check($sformatf("d%02h_done", d), 32'(obs8()), 32'(8'b0110_0000));
        link8.valid = keep_valid;
        tick();
        check($sformatf("d%02h_ready_back", d), 32'(obs8()), 32'(RST));
    endtask

    task automatic xfer4(input logic [3:0] d, input logic dr);
        int n;
        link4.valid   = 1'b1;
        link4.data_in = d;
        link4.dir     = dr;
        tick();
        link4.valid   = 1'b0;
        link4.data_in = 4'($urandom);
        n = 0;
        while (done4 !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("lb_done", 32'(done4), 32'd1);
        check($sformatf("lb_q_%0h", d), 32'(q), 32'(d));
        tick();
        check("lb_idle", 32'(obs4()), 32'(RST));
    endtask

    initial begin
        mr            = 1'b0;
        q             = 4'b0000;
        link8.valid   = 1'b0;
        link8.data_in = '0;
        link8.dir     = 1'b0;
        link4.valid   = 1'b0;
        link4.data_in = '0;
        link4.dir     = 1'b0;

        repeat (2) begin
            link8.valid   = 1'($urandom);
            link8.data_in = 8'($urandom);
            link8.dir     = 1'($urandom);
            link4.valid   = 1'($urandom);
            link4.data_in = 4'($urandom);
            tick();
        end
        check("reset8", 32'(obs8()), 32'(RST));
        check("reset4", 32'(obs4()), 32'(RST));
        link8.valid = 1'b0;
        link4.valid = 1'b0;
        mr          = 1'b1;
        tick();
        check("idle8", 32'(obs8()), 32'(RST));

        xfer8(8'hA5, 1'b0, 1'b0, -1);
        xfer8(8'hC1, 1'b1, 1'b0, -1);

        xfer8(8'h0F, 1'b0, 1'b1, -1);
        xfer8(8'hF0, 1'b0, 1'b0, -1);
        repeat (3) begin
            tick();
            check("post_b2b_idle", 32'(obs8()), 32'(RST));
        end

        xfer8(8'($urandom), 1'($urandom), 1'b0, 16);
        xfer8(8'h3C, 1'b0, 1'b0, -1);

        repeat (6) xfer8(8'($urandom), 1'($urandom), 1'($urandom), -1);
        link8.valid = 1'b0;

        xfer4(4'h9, 1'b0);
        xfer4(4'h6, 1'b1);
        xfer4(4'hB, 1'b0);
        xfer4(4'hB, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
